// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: skid FSM states,
// per-stage control widths and control-field bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // Control bundle widths for each stage boundary
    localparam int IF_ID_CTRL_W  = 1;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int EX_MEM_CTRL_W = 10;
    localparam int MEM_WB_CTRL_W = 7;

    // ID/EX control field positions
    localparam int ID_EX_REGWRITE  = 0;
    localparam int ID_EX_MEMTOREG  = 1;
    localparam int ID_EX_MEMREAD   = 2;
    localparam int ID_EX_MEMWRITE  = 3;
    localparam int ID_EX_ALUSRC    = 4;
    localparam int ID_EX_ALUOP_LSB = 5;
    localparam int ID_EX_ALUOP_W   = 3;
    localparam int ID_EX_RD_LSB    = 8;
    localparam int ID_EX_RD_W      = 5;
    localparam int ID_EX_BRANCH    = 13;
    localparam int ID_EX_JUMP      = 14;
    localparam int ID_EX_REGDST    = 15;

    // EX/MEM control field positions
    localparam int EX_MEM_REGWRITE = 0;
    localparam int EX_MEM_MEMTOREG = 1;
    localparam int EX_MEM_MEMREAD  = 2;
    localparam int EX_MEM_MEMWRITE = 3;
    localparam int EX_MEM_RD_LSB   = 4;
    localparam int EX_MEM_BRANCH   = 9;

    // MEM/WB control field positions
    localparam int MEM_WB_REGWRITE = 0;
    localparam int MEM_WB_MEMTOREG = 1;
    localparam int MEM_WB_RD_LSB   = 2;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One {ctrl, data} entry register; flush zeroes ctrl and, if CLEAR_DATA, data.
module pipe_entry_reg #(
    parameter int CTRL_W     = 16,
    parameter int PAY_W      = 96,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [PAY_W-1:0]  data_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [PAY_W-1:0]  data_o
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [PAY_W-1:0]  data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (clr_i) begin
            ctrl_q <= '0;
            if (CLEAR_DATA) data_q <= '0;
        end else if (load_i) begin
            ctrl_q <= ctrl_i;
            data_q <= data_i;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with valid/ready handshake and 2-entry skid buffer.
// Optional perf counters (stall_cnt_o, flush_cnt_o) enabled by PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DATA   = 3,
    parameter int CTRL_W     = 16,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       start_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [CTRL_W-1:0]          ctrl_i,
    input  logic [NUM_DATA*DATA_W-1:0] data_i,
    input  logic                       flush_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [CTRL_W-1:0]          ctrl_o,
    output logic [NUM_DATA*DATA_W-1:0] data_o
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cnt_o,
    output logic [31:0]                flush_cnt_o
`endif
);

    localparam int PAY_W = NUM_DATA * DATA_W;

    pipe_state_e state_q;
    logic        valid_q, ready_q;
    logic        accept, emit;
    logic        main_load, skid_load;

    logic [CTRL_W-1:0] main_ctrl_d, main_ctrl_q, skid_ctrl_q;
    logic [PAY_W-1:0]  main_data_d, main_data_q, skid_data_q;

    assign accept = valid_i & ready_q;
    assign emit   = valid_q & ready_i;

    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        case (state_q)
            EMPTY: main_load = accept;
            FULL: begin
                main_load = accept & emit;
                skid_load = accept & ~emit;
            end
            SKID:    main_load = emit;
            default: ;
        endcase
    end

    // In SKID the main register refills from the skid slot, otherwise from upstream
    assign main_ctrl_d = (state_q == SKID) ? skid_ctrl_q : ctrl_i;
    assign main_data_d = (state_q == SKID) ? skid_data_q : data_i;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (flush_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_q <= FULL;
                    valid_q <= 1'b1;
                end
                FULL: if (emit && !accept) begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                end else if (accept && !emit) begin
                    state_q <= SKID;
                    ready_q <= 1'b0;
                end
                SKID: if (emit) begin
                    state_q <= FULL;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    pipe_entry_reg #(.CTRL_W(CTRL_W), .PAY_W(PAY_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
        .clk_i  (clk_i),
        .rst_ni (start_i),
        .load_i (main_load),
        .clr_i  (flush_i),
        .ctrl_i (main_ctrl_d),
        .data_i (main_data_d),
        .ctrl_o (main_ctrl_q),
        .data_o (main_data_q)
    );

    pipe_entry_reg #(.CTRL_W(CTRL_W), .PAY_W(PAY_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
        .clk_i  (clk_i),
        .rst_ni (start_i),
        .load_i (skid_load),
        .clr_i  (flush_i),
        .ctrl_i (ctrl_i),
        .data_i (data_i),
        .ctrl_o (skid_ctrl_q),
        .data_o (skid_data_q)
    );

    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign ctrl_o  = valid_q ? main_ctrl_q : '0;
    assign data_o  = main_data_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (valid_q && !ready_i) stall_cnt_q <= sat_inc32(stall_cnt_q);
            if (flush_i && (state_q != EMPTY || valid_i)) flush_cnt_q <= sat_inc32(flush_cnt_q);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
